fadd_result_uart_tx: RTL

//  Consumer end of the fadd result handshake: captures answer when answer_ready is high, serialises it as

---
 rtl/fadd_result_uart_tx.sv | 134 +++++++++++++
 1 files changed

// File: rtl/fadd_result_uart_tx.sv
// Consumer end of the fadd result handshake: latches a 32-bit answer and sends it as
// four 8N1 UART bytes on txd, then pulses received once per captured result.
`timescale 1ns/1ps
module fadd_result_uart_tx #(
   parameter int unsigned CLK_PER_HALF_BIT = 5208,
   parameter bit          MSB_BYTE_FIRST   = 1'b1
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [31:0] answer,
   input  logic        answer_ready,
   output logic        received,
   output logic        txd,
   output logic        busy
);

   localparam int unsigned BP = 2 * CLK_PER_HALF_BIT;
   localparam int unsigned CW = (BP > 1) ? $clog2(BP) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(BP - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_DONE,
      S_WAIT_DROP
   } state_t;

   state_t        state;
   logic [31:0]   shift_buf;
   logic [CW-1:0] bit_cnt;
   logic [2:0]    bit_idx;
   logic [1:0]    byte_idx;
   logic [1:0]    byte_sel;
   logic [7:0]    cur_byte;
   logic [2:0]    next_bit;
   logic          bit_end;

   always_comb begin
      byte_sel = MSB_BYTE_FIRST ? (2'd3 - byte_idx) : byte_idx;
      cur_byte = shift_buf[{byte_sel, 3'b000} +: 8];
      next_bit = bit_idx + 3'd1;
      bit_end  = (bit_cnt == CNT_LAST);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state     <= S_IDLE;
         txd       <= 1'b1;
         received  <= 1'b0;
         busy      <= 1'b0;
         bit_cnt   <= '0;
         bit_idx   <= '0;
         byte_idx  <= '0;
         shift_buf <= '0;
      end else begin
         received <= 1'b0;
         case (state)
            S_IDLE: begin
               txd     <= 1'b1;
               busy    <= 1'b0;
               bit_cnt <= '0;
               if (answer_ready) begin
                  shift_buf <= answer;
                  byte_idx  <= '0;
                  bit_idx   <= '0;
                  busy      <= 1'b1;
                  txd       <= 1'b0;
                  state     <= S_START;
               end
            end
            S_START: begin
               if (bit_end) begin
                  bit_cnt <= '0;
                  bit_idx <= '0;
                  txd     <= cur_byte[0];
                  state   <= S_DATA;
               end else begin
                  bit_cnt <= bit_cnt + CW'(1);
               end
            end
            S_DATA: begin
               if (bit_end) begin
                  bit_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     txd   <= 1'b1;
                     state <= S_STOP;
                  end else begin
                     bit_idx <= next_bit;
                     txd     <= cur_byte[next_bit];
                  end
               end else begin
                  bit_cnt <= bit_cnt + CW'(1);
               end
            end
            S_STOP: begin
               if (bit_end) begin
                  bit_cnt <= '0;
                  if (byte_idx == 2'd3) begin
                     received <= 1'b1;
                     state    <= S_DONE;
                  end else begin
                     // next start bit follows the stop bit with no idle gap
                     byte_idx <= byte_idx + 2'd1;
                     txd      <= 1'b0;
                     state    <= S_START;
                  end
               end else begin
                  bit_cnt <= bit_cnt + CW'(1);
               end
            end
            S_DONE: begin
               txd   <= 1'b1;
               state <= S_WAIT_DROP;
            end
            S_WAIT_DROP: begin
               // hold off until the producer withdraws ready, so one result yields one frame
               txd <= 1'b1;
               if (!answer_ready) begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
            end
            default: begin
               txd   <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
